// File: rtl/operand_loader.sv
// Operand entry front-end: debounced "enter" button steps switch values into
// operands a, b and opcode, then offers them to the ALU with a one-beat handshake.
module operand_loader #(
  parameter int M        = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] sw,
  input  logic         btn,
  input  logic         ready,
  output logic [M-1:0] a,
  output logic [M-1:0] b,
  output logic [3:0]   op,
  output logic         valid,
  output logic         div_zero,
  output logic [2:0]   state
);

  localparam int CNT_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_OP    = 3'd2,
    S_VALID = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             btn_p0, btn_p1;
  logic [CNT_W-1:0] db_cnt_p2;
  logic             db_fired_p2;
  logic             press;
  logic             load_a, load_b, load_op;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
    end
  end

  // Stage p2: saturating debounce counter; the fired flag keeps a long hold to one pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_p2   <= '0;
      db_fired_p2 <= 1'b0;
    end else if (!btn_p1) begin
      db_cnt_p2   <= '0;
      db_fired_p2 <= 1'b0;
    end else begin
      db_cnt_p2 <= sat_inc(db_cnt_p2);
      if (press) db_fired_p2 <= 1'b1;
    end
  end

  assign press = (db_cnt_p2 == CNT_MAX) && !db_fired_p2;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_A;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    case (state_q)
      S_A:     if (press) begin load_a  = 1'b1; state_d = S_B;     end
      S_B:     if (press) begin load_b  = 1'b1; state_d = S_OP;    end
      S_OP:    if (press) begin load_op = 1'b1; state_d = S_VALID; end
      S_VALID: if (ready) state_d = S_DONE;
      S_DONE:  if (press) state_d = S_A;
      default: state_d = S_A;
    endcase
  end

  // Operands hold through S_VALID and S_DONE so the ALU result stays displayed
  always_ff @(posedge clk) begin
    if (rst) begin
      a  <= '0;
      b  <= '0;
      op <= '0;
    end else begin
      if (load_a)  a  <= sw;
      if (load_b)  b  <= sw;
      if (load_op) op <= sw[3:0];
    end
  end

  assign state    = state_q;
  assign valid    = (state_q == S_VALID);
  assign div_zero = ((state_q == S_VALID) || (state_q == S_DONE)) &&
                    (op == 4'h3) && (b == '0);

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed scenarios plus randomized button/switch
// traffic, all outputs compared every cycle against a behavioural model.
module tb_operand_loader;

  localparam int M = 4;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst, btn, ready;
  logic [M-1:0] sw;
  logic [M-1:0] a, b;
  logic [3:0]   op;
  logic         valid, div_zero;
  logic [2:0]   state;

  int total = 0;
  int bad   = 0;
  int valid_cycles;
  logic [2:0] state_log[$];

  always #5 clk = ~clk;

  operand_loader #(.M(M), .DEBOUNCE(D)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .ready(ready),
    .a(a), .b(b), .op(op), .valid(valid), .div_zero(div_zero), .state(state)
  );

  // Reference model: button run length after a 2-sample delay, phase 0..4
  logic         m_s1 = 1'b0, m_s2 = 1'b0;
  int           m_run = 0;
  int           m_phase = 0;
  logic [M-1:0] m_a = '0, m_b = '0;
  logic [3:0]   m_op = '0;
  bit           m_press;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0; m_phase = 0;
      m_a = '0; m_b = '0; m_op = '0;
    end else begin
      m_press = (m_run == D);
      m_run   = m_s2 ? ((m_run > D) ? m_run : m_run + 1) : 0;
      m_s2    = m_s1;
      m_s1    = btn;
      case (m_phase)
        0: if (m_press) begin m_a = sw; m_phase = 1; end
        1: if (m_press) begin m_b = sw; m_phase = 2; end
        2: if (m_press) begin m_op = sw[3:0]; m_phase = 3; end
        3: if (ready) m_phase = 4;
        4: if (m_press) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_phase));
    chk("valid", 32'(valid), 32'(m_phase == 3));
    chk("a", 32'(a), 32'(m_a));
    chk("b", 32'(b), 32'(m_b));
    chk("op", 32'(op), 32'(m_op));
    chk("div_zero", 32'(div_zero), 32'(m_phase >= 3 && m_op == 4'h3 && m_b == '0));
  endtask

  task automatic step(input logic b_v, input logic [M-1:0] s_v, input logic r_v, input logic rst_v);
    btn = b_v; sw = s_v; ready = r_v; rst = rst_v;
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (valid === 1'b1) valid_cycles++;
    if (state_log.size() == 0 || state_log[$] !== state) state_log.push_back(state);
  endtask

  task automatic press(input logic [M-1:0] v, input logic r_v);
    for (int i = 0; i < D + 4; i++) step(1'b1, v, r_v, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, M'($urandom), r_v, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, M'($urandom), 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; sw = '0; ready = 1'b0;
    valid_cycles = 0;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("rst_state", 32'(state), 0);
    chk("rst_a", 32'(a), 0);
    chk("rst_b", 32'(b), 0);
    chk("rst_op", 32'(op), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_div_zero", 32'(div_zero), 0);

    // Full sequence with ready held high
    state_log.delete();
    state_log.push_back(state);
    valid_cycles = 0;
    press(4'h9, 1'b1);
    press(4'h3, 1'b1);
    press(4'h1, 1'b1);
    chk("seq_a", 32'(a), 32'h9);
    chk("seq_b", 32'(b), 32'h3);
    chk("seq_op", 32'(op), 32'h1);
    chk("seq_state", 32'(state), 4);
    chk("seq_valid_cycles", 32'(valid_cycles), 1);
    chk("seq_len", 32'(state_log.size()), 5);
    for (int i = 0; i < 5; i++) chk("seq_order", 32'(state_log[i]), 32'(i));
    press(4'hc, 1'b1);
    chk("done_to_a", 32'(state), 0);
    chk("done_keeps_a", 32'(a), 32'h9);

    // Bounce rejection
    valid_cycles = 0;
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b0, 4'h5, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b0, 4'h5, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 4'h5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, M'($urandom), 1'b0, 1'b0);
    chk("bounce_state", 32'(state), 1);
    chk("bounce_a", 32'(a), 32'h5);
    chk("bounce_valid_cycles", 32'(valid_cycles), 0);

    // Backpressure with presses during S_VALID
    do_reset();
    press(4'h5, 1'b0);
    press(4'h6, 1'b0);
    press(4'h2, 1'b0);
    chk("bp_enter_valid", 32'(state), 3);
    press(4'h9, 1'b0);
    press(4'hf, 1'b0);
    chk("bp_state", 32'(state), 3);
    chk("bp_valid", 32'(valid), 1);
    chk("bp_a", 32'(a), 32'h5);
    chk("bp_b", 32'(b), 32'h6);
    chk("bp_op", 32'(op), 32'h2);
    step(1'b0, M'($urandom), 1'b1, 1'b0);
    chk("bp_release", 32'(state), 4);
    chk("bp_valid_low", 32'(valid), 0);

    // Divide by zero
    do_reset();
    press(4'h7, 1'b0);
    press(4'h0, 1'b0);
    press(4'h3, 1'b0);
    chk("dz_valid_state", 32'(div_zero), 1);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("dz_done_state", 32'(state), 4);
    chk("dz_done", 32'(div_zero), 1);
    press(4'h0, 1'b0);
    chk("dz_back_state", 32'(state), 0);
    chk("dz_cleared", 32'(div_zero), 0);

    // Reset in S_OP on the cycle a press qualifies, then a fresh qualification
    do_reset();
    press(4'h1, 1'b0);
    press(4'h2, 1'b0);
    chk("mid_in_op", 32'(state), 2);
    for (int i = 0; i < D + 2; i++) step(1'b1, 4'h4, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b1, 1'b1);
    chk("mid_state", 32'(state), 0);
    chk("mid_a", 32'(a), 0);
    chk("mid_b", 32'(b), 0);
    chk("mid_op", 32'(op), 0);
    chk("mid_valid", 32'(valid), 0);
    for (int i = 0; i < D + 4; i++) step(1'b1, 4'h4, 1'b0, 1'b0);
    chk("requal_state", 32'(state), 1);
    chk("requal_a", 32'(a), 32'h4);
    for (int i = 0; i < 3; i++) step(1'b0, M'($urandom), 1'b0, 1'b0);

    // Long hold advances once
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b1, 4'hb, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, M'($urandom), 1'b0, 1'b0);
    chk("hold_state", 32'(state), 1);
    chk("hold_a", 32'(a), 32'hb);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int hold, gap;
      logic [M-1:0] v;
      hold = int'($urandom_range(1, D + 6));
      gap  = int'($urandom_range(1, 4));
      v    = M'($urandom);
      for (int i = 0; i < hold; i++)
        step(1'b1, v, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 49) == 0));
      for (int i = 0; i < gap; i++)
        step(1'b0, M'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL have parameter M, default 4: width of operands a and b; legal values M >= 4.
REQ-002 The block SHALL have parameter DEBOUNCE, default 3: consecutive high synchronized samples that qualify a button press; legal values >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port sw, input, M bits: switch value being loaded.
REQ-006 The block SHALL have port btn, input, 1 bit: raw asynchronous "enter" push-button.
REQ-007 The block SHALL have port ready, input, 1 bit: the downstream ALU stage (add/sub/mul/div) accepts the operands.
REQ-008 The block SHALL have port a, output, M bits: operand A to the ALU.
REQ-009 The block SHALL have port b, output, M bits: operand B to the ALU.
REQ-010 The block SHALL have port op, output, 4 bits: operation code to the ALU.
REQ-011 The block SHALL have port valid, output, 1 bit: a, b and op are stable and offered to the ALU.
REQ-012 The block SHALL have port div_zero, output, 1 bit: a division by zero is pending or was just issued.
REQ-013 The block SHALL have port state, output, 3 bits: current FSM state encoding, driven to LEDs.

Function
REQ-014 The block SHALL pass btn through a 2-flop synchronizer before any other use.
REQ-015 A debounce counter SHALL increment while the synchronized btn is 1 and clear to 0 when it is 0.
REQ-016 A single-cycle internal press pulse SHALL assert on the cycle the counter reaches DEBOUNCE, with the counter saturating there.
REQ-017 After a press pulse, no further pulse SHALL be generated until the synchronized btn has been sampled 0 at least once.
REQ-018 If btn is first sampled high at edge k and held high, the press pulse SHALL be high during the cycle after edge k+1+DEBOUNCE.
REQ-019 The FSM SHALL have these states with these encodings: S_A=3'd0, S_B=3'd1, S_OP=3'd2, S_VALID=3'd3, S_DONE=3'd4; state SHALL output the encoding.
REQ-020 In S_A, on a press, a SHALL load sw and the FSM SHALL go to S_B.
REQ-021 In S_B, on a press, b SHALL load sw and the FSM SHALL go to S_OP.
REQ-022 In S_OP, on a press, op SHALL load sw[3:0] and the FSM SHALL go to S_VALID.
REQ-023 valid SHALL be 1 exactly while the FSM is in S_VALID, i.e. registered, one cycle after the op-capturing edge.
REQ-024 In S_VALID, presses SHALL be ignored, and a, b and op SHALL hold.
REQ-025 In S_VALID, on the first edge with ready=1, the FSM SHALL go to S_DONE, so valid falls on the next cycle; the transfer is one beat.
REQ-026 ready SHALL be ignored in all states other than S_VALID.
REQ-027 In S_DONE, a, b and op SHALL hold so the downstream result stays displayed.
REQ-028 In S_DONE, a press SHALL return the FSM to S_A without clearing a, b or op.
REQ-029 div_zero SHALL be combinational from registers: 1 when the state is S_VALID or S_DONE, op == 4'h3 (divide) and b == 0; otherwise 0.
REQ-030 div_zero SHALL NOT block the handshake.
REQ-031 Changes on sw between presses SHALL have no effect on any output.

Reset
REQ-032 With rst=1 at an edge, the block SHALL set state=S_A, a=0, b=0, op=0, valid=0, both synchronizer flops=0 and the debounce counter=0; div_zero is therefore 0.
REQ-033 rst SHALL take priority over press and ready in the same cycle, including when asserted mid-sequence or during S_VALID.
REQ-034 After reset, a btn held high SHALL produce a pulse only after a fresh DEBOUNCE-count qualification, and REQ-017 SHALL apply to it.

Verification
REQ-035 Full sequence (M=4, DEBOUNCE=3): press with sw=4'h9, then 4'h3, then 4'h1 (add), ready=1 -> a=9, b=3, op=1; valid high for exactly 1 cycle; state sequence 0,1,2,3,4.
REQ-036 Bounce rejection: btn toggles 1,0,1,0 (1 cycle each), then held high for 6 cycles -> exactly one press; valid stays 0.
REQ-037 Backpressure: hold ready=0 for 10 cycles in S_VALID and press twice -> valid stays 1, a/b/op unchanged, state stays 3; ready=1 -> state 4 next cycle.
REQ-038 Divide by zero: sw=4'h7, then 4'h0, then op 4'h3 -> div_zero=1 in S_VALID and S_DONE; div_zero=0 after the next press returns to S_A.
REQ-039 Reset mid-operation: rst asserted in S_OP while a press qualifies on the same cycle -> next cycle state=0, a=b=op=0, valid=0.
REQ-040 Held button: btn held high for 50 cycles -> exactly one state advance.
